// File: rtl/nnrv_ram_arb.sv
// Shares one single-port sync RAM between instruction fetch (read-only) and the memory stage (read/write).
// Latency: grant is combinational in the request cycle; read data returns one cycle after the grant.
// Backpressure: the loser keeps req high until granted; MEM has priority, and IF is forced through after MAX_WAIT losses
// (optional strict round-robin arbitration under NNRV_ARB_RR_EN).
module nnrv_ram_arb #(
    parameter int ADDR_WIDTH = 8,
    parameter int XLEN       = 32,
    parameter int MAX_WAIT   = 3
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_if_req,
    input  logic [ADDR_WIDTH-1:0] i_if_addr,
    output logic                  o_if_gnt,
    output logic                  o_if_rvalid,
    output logic [XLEN-1:0]       o_if_rdata,
    input  logic                  i_mem_req,
    input  logic                  i_mem_we,
    input  logic [ADDR_WIDTH-1:0] i_mem_addr,
    input  logic [3:0]            i_mem_mask,
    input  logic [XLEN-1:0]       i_mem_wdata,
    output logic                  o_mem_gnt,
    output logic                  o_mem_rvalid,
    output logic [XLEN-1:0]       o_mem_rdata,
    output logic                  o_ram_en,
    output logic                  o_ram_we,
    output logic [ADDR_WIDTH-1:0] o_ram_addr,
    output logic [3:0]            o_ram_mask,
    output logic [XLEN-1:0]       o_ram_wdata,
    input  logic [XLEN-1:0]       i_ram_rdata
);

    localparam logic [1:0] TAG_NONE = 2'd0;
    localparam logic [1:0] TAG_IF   = 2'd1;
    localparam logic [1:0] TAG_MEM  = 2'd2;

    logic            if_win;
    logic            mem_win;
    logic            if_go;
    logic            mem_go;
    logic [1:0]      tag;
    logic [XLEN-1:0] if_hold;
    logic [XLEN-1:0] mem_hold;

`ifdef NNRV_ARB_RR_EN
    logic last_if;  // 1 when IF took the most recent grant

    always_comb begin
        if_win  = i_if_req;
        mem_win = i_mem_req;
        if (i_if_req && i_mem_req) begin
            if_win  = !last_if;
            mem_win = last_if;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            last_if <= 1'b0;
        end else if (if_win) begin
            last_if <= 1'b1;
        end else if (mem_win) begin
            last_if <= 1'b0;
        end
    end
`else
    localparam logic [3:0] WAIT_LIM = 4'(MAX_WAIT);

    logic [3:0] starve_cnt;

    always_comb begin
        if_win  = i_if_req;
        mem_win = i_mem_req;
        if (i_if_req && i_mem_req) begin
            if_win  = (starve_cnt == WAIT_LIM);
            mem_win = (starve_cnt != WAIT_LIM);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            starve_cnt <= 4'd0;
        end else if (!i_if_req || if_win) begin
            starve_cnt <= 4'd0;
        end else if (starve_cnt != WAIT_LIM) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end
`endif

    // Outputs are forced quiet while reset is held, even if requests are pending.
    assign if_go    = if_win & i_rst;
    assign mem_go   = mem_win & i_rst;
    assign o_if_gnt  = if_go;
    assign o_mem_gnt = mem_go;

    always_comb begin
        o_ram_en    = 1'b0;
        o_ram_we    = 1'b0;
        o_ram_addr  = '0;
        o_ram_mask  = 4'h0;
        o_ram_wdata = '0;
        if (mem_go) begin
            o_ram_en    = 1'b1;
            o_ram_we    = i_mem_we;
            o_ram_addr  = i_mem_addr;
            o_ram_mask  = i_mem_mask;
            o_ram_wdata = i_mem_wdata;
        end else if (if_go) begin
            o_ram_en   = 1'b1;
            o_ram_addr = i_if_addr;
            o_ram_mask = 4'hF;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            tag <= TAG_NONE;
        end else if (if_win) begin
            tag <= TAG_IF;
        end else if (mem_win && !i_mem_we) begin
            tag <= TAG_MEM;
        end else begin
            tag <= TAG_NONE;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            if_hold  <= '0;
            mem_hold <= '0;
        end else begin
            if (tag == TAG_IF) begin
                if_hold <= i_ram_rdata;
            end
            if (tag == TAG_MEM) begin
                mem_hold <= i_ram_rdata;
            end
        end
    end

    assign o_if_rvalid  = (tag == TAG_IF);
    assign o_mem_rvalid = (tag == TAG_MEM);
    assign o_if_rdata   = o_if_rvalid  ? i_ram_rdata : if_hold;
    assign o_mem_rdata  = o_mem_rvalid ? i_ram_rdata : mem_hold;

endmodule
